mistral_ff_bank_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit bank of MISTRAL_FF-style registers between NREQ requesters. Each granted request is turned into exactly one cycle of ENA/SCLR/SLOAD/SDATA control, applied to an internal shadow register bank. The shadow bank follows Mistral LE flop semantics, so Q always equals what the physical flops would hold. The block sits between soft control logic and a register bank that is synchronous-only apart from the block reset.

---
 rtl/mistral_ff_bank_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mistral_ff_bank_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mistral_ff_bank_arbiter.sv
// rtl/mistral_ff_bank_arbiter.sv - round-robin arbiter sequencing one MISTRAL_FF register bank
module mistral_ff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    ACLR,
    input  logic [NREQ-1:0]         REQ,
    input  logic [2*NREQ-1:0]       OP,
    input  logic [WIDTH*NREQ-1:0]   WDATA,
    input  logic [WIDTH-1:0]        DATAIN,
    output logic [NREQ-1:0]         GNT,
    output logic [NREQ-1:0]         DONE,
    output logic                    ENA,
    output logic                    SCLR,
    output logic                    SLOAD,
    output logic [WIDTH-1:0]        SDATA,
    output logic [WIDTH-1:0]        Q,
    output logic                    BUSY
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_CAPTURE = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_CLEAR   = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              ena_q, ena_d;
    logic              sclr_q, sclr_d;
    logic              sload_q, sload_d;
    logic [WIDTH-1:0]  sdata_q, sdata_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     cand;
    logic [1:0]        win_op;
    logic [WIDTH-1:0]  win_wdata;

    // Search upward from the pointer, wrapping at NREQ; first set REQ wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (!found && REQ[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        win_op    = 2'(OP >> (2 * win_idx));
        win_wdata = WIDTH'(WDATA >> (WIDTH * win_idx));
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        ena_d   = 1'b0;
        sclr_d  = 1'b0;
        sload_d = 1'b0;
        sdata_d = '0;
        q_d     = q_q;

        // Shadow bank mirrors LE flop priority: SCLR over SLOAD over D.
        if (ena_q) begin
            if (sclr_q) begin
                q_d = '0;
            end else if (sload_q) begin
                q_d = sdata_q;
            end else begin
                q_d = DATAIN;
            end
        end

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    win_d   = win_idx;
                    gnt_d   = NREQ'(1) << win_idx;
                    state_d = APPLY;
                    case (win_op)
                        OP_CAPTURE: ena_d = 1'b1;
                        OP_LOAD: begin
                            ena_d   = 1'b1;
                            sload_d = 1'b1;
                            sdata_d = win_wdata;
                        end
                        OP_CLEAR: begin
                            ena_d  = 1'b1;
                            sclr_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            APPLY: begin
                done_d  = NREQ'(1) << win_q;
                state_d = ACK;
            end
            ACK: begin
                ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            ena_q   <= 1'b0;
            sclr_q  <= 1'b0;
            sload_q <= 1'b0;
            sdata_q <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ena_q   <= ena_d;
            sclr_q  <= sclr_d;
            sload_q <= sload_d;
            sdata_q <= sdata_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
        end
    end

    assign GNT   = gnt_q;
    assign DONE  = done_q;
    assign ENA   = ena_q;
    assign SCLR  = sclr_q;
    assign SLOAD = sload_q;
    assign SDATA = sdata_q;
    assign Q     = q_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_mistral_ff_bank_arbiter.sv
// tb/tb_mistral_ff_bank_arbiter.sv - directed bench for mistral_ff_bank_arbiter
module tb_mistral_ff_bank_arbiter;

    logic        CLK;
    logic        ACLR;
    logic [3:0]  REQ;
    logic [7:0]  OP;
    logic [31:0] WDATA;
    logic [7:0]  DATAIN;
    logic [3:0]  GNT;
    logic [3:0]  DONE;
    logic        ENA;
    logic        SCLR;
    logic        SLOAD;
    logic [7:0]  SDATA;
    logic [7:0]  Q;
    logic        BUSY;

    int errors = 0;
    int checks = 0;
    logic [7:0] q_model;
    logic [3:0] exp_gnt;

    mistral_ff_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .CLK(CLK), .ACLR(ACLR), .REQ(REQ), .OP(OP), .WDATA(WDATA), .DATAIN(DATAIN),
        .GNT(GNT), .DONE(DONE), .ENA(ENA), .SCLR(SCLR), .SLOAD(SLOAD),
        .SDATA(SDATA), .Q(Q), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk_ctl(input string tag, input logic e, input logic c, input logic l, input logic [7:0] d);
        chk({tag, "_ena"}, 32'(ENA), 32'(e));
        chk({tag, "_sclr"}, 32'(SCLR), 32'(c));
        chk({tag, "_sload"}, 32'(SLOAD), 32'(l));
        chk({tag, "_sdata"}, 32'(SDATA), 32'(d));
    endtask

    initial begin
        ACLR = 1'b1; REQ = 4'b0; OP = 8'hFF; WDATA = 32'h0; DATAIN = 8'hFF;
        tick(); tick();
        chk("rst_gnt", 32'(GNT), 32'h0);
        chk("rst_done", 32'(DONE), 32'h0);
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk_ctl("rst", 1'b0, 1'b0, 1'b0, 8'h00);

        // Load 0xA5 from requester 2
        ACLR = 1'b0; REQ = 4'b0100; OP = 8'h10; WDATA = 32'h00A5_0000;
        tick();
        chk("ld_gnt", 32'(GNT), 32'h4);
        chk("ld_busy", 32'(BUSY), 32'h1);
        chk_ctl("ld_apply", 1'b1, 1'b0, 1'b1, 8'hA5);
        chk("ld_done_early", 32'(DONE), 32'h0);
        REQ = 4'b0;
        tick();
        chk("ld_gnt_ack", 32'(GNT), 32'h4);
        chk("ld_done", 32'(DONE), 32'h4);
        chk("ld_q", 32'(Q), 32'hA5);
        chk_ctl("ld_ack", 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("ld_idle_gnt", 32'(GNT), 32'h0);
        chk("ld_idle_done", 32'(DONE), 32'h0);
        chk("ld_idle_busy", 32'(BUSY), 32'h0);

        // Pointer is 3: requester 3 (nop) beats requester 0
        REQ = 4'b1001; OP = 8'hC0; DATAIN = 8'hFF;
        tick();
        chk("ptr_gnt", 32'(GNT), 32'h8);
        chk_ctl("ptr_nop", 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("ptr_done", 32'(DONE), 32'h8);
        chk("ptr_q", 32'(Q), 32'hA5);
        REQ = 4'b0001;
        tick();
        chk("ptr_idle_gnt", 32'(GNT), 32'h0);
        tick();
        chk("cap_gnt", 32'(GNT), 32'h1);
        chk_ctl("cap_apply", 1'b1, 1'b0, 1'b0, 8'h00);
        DATAIN = 8'h3C; REQ = 4'b0;
        tick();
        chk("cap_q", 32'(Q), 32'h3C);
        chk("cap_done", 32'(DONE), 32'h1);
        DATAIN = 8'hFF;
        tick();

        // Clear from requester 1
        REQ = 4'b0010; OP = 8'h08;
        tick();
        chk("clr_gnt", 32'(GNT), 32'h2);
        chk_ctl("clr_apply", 1'b1, 1'b1, 1'b0, 8'h00);
        REQ = 4'b0;
        tick();
        chk("clr_q", 32'(Q), 32'h00);
        chk("clr_done", 32'(DONE), 32'h2);
        tick();

        // Requester 3 loads 0x5A, then issues a nop and drops REQ during APPLY
        REQ = 4'b1000; OP = 8'h40; WDATA = 32'h5A00_0000;
        tick();
        chk("l5a_gnt", 32'(GNT), 32'h8);
        REQ = 4'b0;
        tick();
        chk("l5a_q", 32'(Q), 32'h5A);
        tick();
        REQ = 4'b1000; OP = 8'hC0;
        tick();
        chk("nop_gnt", 32'(GNT), 32'h8);
        chk_ctl("nop_apply", 1'b0, 1'b0, 1'b0, 8'h00);
        REQ = 4'b0; OP = 8'h40; WDATA = 32'h0;
        tick();
        chk("nop_done", 32'(DONE), 32'h8);
        chk("nop_q", 32'(Q), 32'h5A);
        chk_ctl("nop_ack", 1'b0, 1'b0, 1'b0, 8'h00);
        tick();

        // ACLR during APPLY of a load of 0xFF
        REQ = 4'b0100; OP = 8'h10; WDATA = 32'h00FF_0000;
        tick();
        chk("abort_pre_sload", 32'(SLOAD), 32'h1);
        #2 ACLR = 1'b1;
        #1;
        chk("abort_gnt", 32'(GNT), 32'h0);
        chk("abort_q", 32'(Q), 32'h0);
        chk("abort_busy", 32'(BUSY), 32'h0);
        chk_ctl("abort", 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("abort_q_edge", 32'(Q), 32'h0);
        chk("abort_done", 32'(DONE), 32'h0);

        // All four held high: req0 load 0x11, req1 capture, req2 clear, req3 load 0x77
        REQ = 4'b1111; OP = 8'h61; WDATA = 32'h7700_0011; DATAIN = 8'h6B;
        ACLR = 1'b0;
        q_model = 8'h00;
        for (int n = 0; n < 12; n++) begin
            tick();
            exp_gnt = 4'b0001 << (n % 4);
            chk($sformatf("rr%0d_gnt", n), 32'(GNT), 32'(exp_gnt));
            case (n % 4)
                0: q_model = 8'h11;
                1: q_model = 8'h6B;
                2: q_model = 8'h00;
                default: q_model = 8'h77;
            endcase
            tick();
            chk($sformatf("rr%0d_done", n), 32'(DONE), 32'(exp_gnt));
            chk($sformatf("rr%0d_q", n), 32'(Q), 32'(q_model));
            tick();
            chk($sformatf("rr%0d_gap", n), 32'(DONE), 32'h0);
        end
        REQ = 4'b0;

        // REQ[1] rises during ACK of requester 0's nop
        REQ = 4'b0001; OP = 8'hFF;
        tick();
        chk("late_gnt0", 32'(GNT), 32'h1);
        tick();
        chk("late_done0", 32'(DONE), 32'h1);
        REQ = 4'b0010;
        tick();
        chk("late_idle", 32'(GNT), 32'h0);
        tick();
        chk("late_gnt1", 32'(GNT), 32'h2);
        REQ = 4'b0;
        tick();
        chk("late_done1", 32'(DONE), 32'h2);
        chk("late_q", 32'(Q), 32'h77);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
